// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive front-end.
//
// Contents:
//   uart_rx_state_t            receiver FSM state encoding
//   UART_CLKS_PER_BIT_DEFAULT  default oversampling ratio (25 MHz / 115200 baud)
//   UART_DATA_BITS             data bits per frame
//   UART_PARITY_BITS           1 when UART_RX_PARITY_EN is defined, else 0
//   UART_FRAME_BITS            start + data + optional parity + stop
//   even_parity_err()          1 when data plus parity bit has odd weight
//
// Optional feature macro: UART_RX_PARITY_EN (8E1 frames instead of 8N1).
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_rx_state_t;

   localparam int UART_CLKS_PER_BIT_DEFAULT = 217;
   localparam int UART_DATA_BITS            = 8;

`ifdef UART_RX_PARITY_EN
   localparam int UART_PARITY_BITS = 1;
`else
   localparam int UART_PARITY_BITS = 0;
`endif

   localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_PARITY_BITS + 1;

   // Even parity: the data byte together with its parity bit must carry an
   // even number of ones, so any odd reduction-XOR is an error.
   function automatic logic even_parity_err(input logic [7:0] data,
                                            input logic       pbit);
      return ^{data, pbit};
   endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_sync_fifo
// Single-clock first-word-fall-through FIFO holding received bytes.
//
// Parameters:
//   WIDTH      entry width in bits
//   DEPTH      number of entries, power of two, at least 2
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset, empties the FIFO
//   push       write push_data this cycle (accepted if not full, or if popping)
//   push_data  entry to write
//   pop        consumer takes the head this cycle (ignored when empty)
//   full       all entries occupied
//   empty      no entries
//   head       oldest entry, valid whenever empty is low
// ----------------------------------------------------------------------------
module uart_rx_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // indices with opposite wrap bits mean full.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A pop in the same cycle frees a slot, so a push into a full FIFO is
   // still accepted when the head is leaving at the same edge.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign head = mem[rd_ptr[AW-1:0]];

   // Storage and pointers. Storage is cleared on reset so the head output
   // reads zero while the FIFO has never been written.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver: synchronises the asynchronous rxd pin, recovers frames by
// mid-bit sampling and queues good bytes in a small FWFT FIFO.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit (minimum 8)
//   FIFO_DEPTH    receive FIFO entries (power of two, minimum 2)
// Ports:
//   clk         system clock
//   resetn      asynchronous active-low reset
//   rxd         serial input, idle high
//   rx_data     FIFO head byte, valid while rx_valid is high
//   rx_valid    FIFO not empty
//   rx_ready    consumer pops the head when rx_valid && rx_ready
//   frame_err   one-cycle pulse, stop bit sampled low
//   parity_err  one-cycle pulse, parity mismatch (0 without parity build)
//   overrun     one-cycle pulse, good byte dropped because FIFO full
//   busy        receiver not idle
//
// Optional feature macro: UART_RX_PARITY_EN selects 8E1 framing and drives
// parity_err; without it frames are 8N1 and parity_err is tied low.
// ----------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_DEPTH   = 4
)(
   input  logic       clk,
   input  logic       resetn,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun,
   output logic       busy
);

   localparam int              CW            = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]   HALF_BIT_LOAD = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0]   FULL_BIT_LOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]      LAST_BIT      = 3'(UART_DATA_BITS - 1);

   logic           rxd_meta;
   logic           rxd_s;
   logic           rxd_prev;
   uart_rx_state_t state;
   logic [CW-1:0]  bit_cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shift_reg;
   logic           par_flag;
   logic           bit_tick;
   logic           stop_sample;
   logic           push_req;
   logic           pop_fire;
   logic           fifo_full;
   logic           fifo_empty;

   // Two-flop synchronizer on the pin plus one more stage so a start edge
   // can be seen as "was high, now low". All stages idle high.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
         rxd_prev <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
         rxd_prev <= rxd_s;
      end
   end

   assign bit_tick    = (bit_cnt == '0);
   assign stop_sample = (state == ST_STOP) && bit_tick;

   // A byte is offered to the FIFO on the stop-sample edge itself so it is
   // visible on rx_valid the very next cycle.
   assign push_req = stop_sample && rxd_s && !par_flag;
   assign pop_fire = rx_ready && !fifo_empty;
   assign rx_valid = !fifo_empty;

`ifndef UART_RX_PARITY_EN
   assign par_flag   = 1'b0;
   assign parity_err = 1'b0;
`endif

   // Receiver FSM. The counter is loaded with half a bit on the start edge so
   // every later sample lands mid-bit, then with a full bit after each
   // sample. Error and overrun flags are registered one-cycle pulses.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         busy       <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_flag   <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (rxd_prev && !rxd_s) begin
                  bit_cnt  <= HALF_BIT_LOAD;
                  state    <= ST_START;
                  busy     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  par_flag <= 1'b0;
`endif
               end
            end

            ST_START: begin
               if (bit_tick) begin
                  if (rxd_s) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     bit_cnt <= FULL_BIT_LOAD;
                     bit_idx <= '0;
                     state   <= ST_DATA;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CW'(1);
               end
            end

            ST_DATA: begin
               if (bit_tick) begin
                  shift_reg <= {rxd_s, shift_reg[7:1]};
                  bit_cnt   <= FULL_BIT_LOAD;
                  if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state <= ST_PARITY;
`else
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - CW'(1);
               end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (bit_tick) begin
                  par_flag <= even_parity_err(shift_reg, rxd_s);
                  bit_cnt  <= FULL_BIT_LOAD;
                  state    <= ST_STOP;
               end else begin
                  bit_cnt <= bit_cnt - CW'(1);
               end
            end
`endif

            ST_STOP: begin
               if (bit_tick) begin
                  frame_err <= !rxd_s;
`ifdef UART_RX_PARITY_EN
                  parity_err <= rxd_s && par_flag;
`endif
                  overrun   <= push_req && fifo_full && !pop_fire;
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt - CW'(1);
               end
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   uart_rx_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push_req),
      .push_data (shift_reg),
      .pop       (rx_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (rx_data)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo. Frames are driven bit by bit on rxd;
// a queue-based model of the receive FIFO and expected pulse counts are kept
// in the bench and compared against the DUT after each directed step.
// Optional feature macro: UART_RX_PARITY_EN (bench then sends 8E1 frames).
// ----------------------------------------------------------------------------
module tb_uart_rx_fifo;
   import uart_pkg::*;

   localparam int CPB   = 217;
   localparam int DEPTH = 4;
   localparam int HALF  = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic       clk = 1'b0;
   logic       resetn;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;
   logic       busy;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .rxd        (rxd),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Free-running edge counter used for latency measurements.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Count cycles each pulse output is high, and note when rx_valid rises.
   int   frame_cyc = 0;
   int   par_cyc   = 0;
   int   ovr_cyc   = 0;
   int   busy_cyc  = 0;
   int   rise_cyc  = 0;
   logic valid_d   = 1'b0;
   always @(negedge clk) begin
      if (frame_err)  frame_cyc++;
      if (parity_err) par_cyc++;
      if (overrun)    ovr_cyc++;
      if (busy)       busy_cyc++;
      if (rx_valid && !valid_d) rise_cyc = cyc;
      valid_d = rx_valid;
   end

   // Expected receiver behaviour: FIFO contents and pulse counts.
   logic [7:0] q[$];
   int exp_frame = 0;
   int exp_par   = 0;
   int exp_ovr   = 0;
   int last_start = 0;

   // Stop the run if something stalls the sequence.
   initial begin
      #(10 * 200000);
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reference outcome of one complete frame.
   task automatic modelFrame(input logic [7:0] data, input logic stop_val,
                             input logic par_flip, input logic pop_at_stop);
      if (!stop_val) begin
         exp_frame++;
      end else if (par_flip && PAR_BITS == 1) begin
         exp_par++;
      end else begin
         if (pop_at_stop && q.size() > 0) void'(q.pop_front());
         if (q.size() < DEPTH) q.push_back(data);
         else                  exp_ovr++;
      end
   endtask

   // Drive one frame starting just after a rising edge. With pop_at_stop the
   // consumer is ready for exactly the stop-sample cycle, which falls
   // 2 (synchronizer) + HALF edges into the stop bit.
   task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                input logic par_flip, input logic pop_at_stop);
      rxd = 1'b0;
      last_start = cyc;
      tick(CPB);
      for (int k = 0; k < 8; k++) begin
         rxd = data[k];
         tick(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^data) ^ par_flip;
      tick(CPB);
`endif
      rxd = stop_val;
      for (int c = 0; c < CPB; c++) begin
         @(posedge clk);
         #1;
         if (pop_at_stop && c == HALF + 1)      rx_ready = 1'b1;
         else if (pop_at_stop && c == HALF + 2) rx_ready = 1'b0;
      end
      rxd = 1'b1;
      modelFrame(data, stop_val, par_flip, pop_at_stop);
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "/valid"}, rx_valid, q.size() != 0);
      if (q.size() != 0) checkOutput({tag, "/head"}, rx_data, q[0]);
      checkOutput({tag, "/frame_err"},  frame_cyc, exp_frame);
      checkOutput({tag, "/parity_err"}, par_cyc,   exp_par);
      checkOutput({tag, "/overrun"},    ovr_cyc,   exp_ovr);
   endtask

   // Pop every expected byte, one handshake per cycle, checking order.
   task automatic drainFifo(input string tag);
      while (q.size() > 0) begin
         checkOutput({tag, "/drain_valid"}, rx_valid, 1'b1);
         checkOutput({tag, "/drain_data"},  rx_data,  q[0]);
         rx_ready = 1'b1;
         tick(1);
         rx_ready = 1'b0;
         void'(q.pop_front());
      end
      checkOutput({tag, "/drained"}, rx_valid, 1'b0);
   endtask

   initial begin
      logic [7:0] stream [5];
      logic [7:0] partial;
      logic [7:0] rb;
      int         b0;

      stream[0] = 8'h34; stream[1] = 8'h35; stream[2] = 8'h2A;
      stream[3] = 8'h34; stream[4] = 8'h32;

      resetn   = 1'b0;
      rxd      = 1'b1;
      rx_ready = 1'b0;
      tick(3);
      checkOutput("reset/rx_valid", rx_valid, 1'b0);
      checkOutput("reset/rx_data",  rx_data,  8'h00);
      checkOutput("reset/busy",     busy,     1'b0);
      checkOutput("reset/pulses",   {frame_err, parity_err, overrun}, 3'b000);
      resetn = 1'b1;
      tick(5);
      checkModel("idle");

      $display("[TB] single byte 0x34, latency");
      b0 = busy_cyc;
      applyStimulus(8'h34, 1'b1, 1'b0, 1'b0);
      checkOutput("t1/latency", rise_cyc - last_start,
                  2 + HALF + (9 + PAR_BITS) * CPB + 1);
      checkOutput("t1/busy_cycles", busy_cyc - b0, HALF + (9 + PAR_BITS) * CPB);
      checkModel("t1");
      drainFifo("t1");

      $display("[TB] five back-to-back bytes, no consumer");
      for (int i = 0; i < 5; i++) applyStimulus(stream[i], 1'b1, 1'b0, 1'b0);
      checkModel("t2");
      drainFifo("t2");

      $display("[TB] five bytes, pop during fifth stop sample");
      for (int i = 0; i < 5; i++) applyStimulus(stream[i], 1'b1, 1'b0, i == 4);
      checkModel("t3");
      drainFifo("t3");

      $display("[TB] 50-cycle glitch");
      b0 = busy_cyc;
      rxd = 1'b0;
      tick(50);
      rxd = 1'b1;
      tick(2 * CPB);
      checkOutput("t4/busy_cycles", busy_cyc - b0, HALF);
      checkModel("t4");

      $display("[TB] frame error with held break, then 0x2F");
      b0 = busy_cyc;
      applyStimulus(8'h39, 1'b0, 1'b0, 1'b0);
      rxd = 1'b0;
      tick(3 * CPB);
      rxd = 1'b1;
      tick(CPB);
      checkOutput("t5/busy_cycles", busy_cyc - b0, HALF + (9 + PAR_BITS) * CPB);
      checkModel("t5");
      applyStimulus(8'h2F, 1'b1, 1'b0, 1'b0);
      tick(UART_FRAME_BITS);
      checkModel("t5b");

      $display("[TB] reset mid-frame of 0x33");
      partial = 8'h33;
      rxd = 1'b0;
      tick(CPB);
      for (int k = 0; k < 4; k++) begin
         rxd = partial[k];
         tick(CPB);
      end
      rxd = partial[4];
      tick(HALF);
      resetn = 1'b0;
      #2;
      checkOutput("t6/rst_valid", rx_valid, 1'b0);
      checkOutput("t6/rst_data",  rx_data,  8'h00);
      checkOutput("t6/rst_busy",  busy,     1'b0);
      checkOutput("t6/rst_pulses", {frame_err, parity_err, overrun}, 3'b000);
      q.delete();
      rxd = 1'b1;
      tick(3);
      resetn = 1'b1;
      tick(2 * CPB);
      checkModel("t6");
      applyStimulus(8'h30, 1'b1, 1'b0, 1'b0);
      checkModel("t6b");
      drainFifo("t6");

`ifdef UART_RX_PARITY_EN
      $display("[TB] 0x30 with wrong parity");
      applyStimulus(8'h30, 1'b1, 1'b1, 1'b0);
      checkModel("t6p");
`endif

      $display("[TB] random bytes with random pops at stop");
      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom_range(0, 255));
         applyStimulus(rb, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
         checkModel("t7");
      end
      drainFifo("t7");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receive front-end for the SoC: oversamples the asynchronous `RXD` pin, recovers 8N1 frames (optional parity), and buffers received bytes in a small first-word-fall-through FIFO. The CPU-side UART register block reads bytes through a valid/ready port. It sits directly downstream of the board/bench `RXD` line and upstream of the memory-mapped UART data/status registers.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per bit; 25 MHz / 115200 baud; minimum 8.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, minimum 2.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; one clock domain, asynchronous assert, active-low.
- `rxd`  in  1  asynchronous serial input; idle high.
- `rx_data`  out  8  FIFO head byte; valid when `rx_valid`=1.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer pops the head when `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse; stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse; parity mismatch. Tied 0 without the parity build.
- `overrun`  out  1  one-cycle pulse; good byte dropped because FIFO full.
- `busy`  out  1  receiver in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer, reset to 1, giving `rxd_s`. All decisions use `rxd_s`.
- FSM states: IDLE, START, DATA, PARITY (parity build only), STOP.
- IDLE: a falling edge on `rxd_s` (previous 1, current 0) loads the bit counter with `CLKS_PER_BIT/2 - 1` and moves to START.
- START: at counter zero, sample `rxd_s`.
  - 1: false start; return to IDLE with no flags.
  - 0: reload the counter with `CLKS_PER_BIT - 1`, clear the bit index, and go to DATA.
- DATA: at each counter zero, shift `rxd_s` into bit `[7]` of the shift register (LSB first) and reload the counter. After bit index 7, go to PARITY or STOP.
- PARITY: sample one bit. Even parity across data and parity bit. A mismatch sets an internal error flag.
- STOP: sample at counter zero.
  - `rxd_s`=0: pulse `frame_err` and discard the byte.
  - Else, parity flag set: pulse `parity_err` and discard.
  - Else: push to FIFO. If FIFO full and not popping this cycle, pulse `overrun` and discard.
  - Always return to IDLE. A held-low line (break) cannot restart until `rxd_s` returns high, because IDLE requires a falling edge.
- FIFO behaviour:
  - `rx_data` is the head entry, registered from storage.
  - Push and pop in the same cycle are both honoured, including when full: the pop frees the slot for the push, so no overrun.
  - Pointers are `$clog2(FIFO_DEPTH)+1` bits; the MSB distinguishes full from empty; pointers wrap naturally.
- Reset (asynchronous, any time including mid-frame): FSM to IDLE, counters 0, FIFO emptied, synchronizer to 1.
  - All outputs 0 during reset: `rx_data`=0x00, `rx_valid`=0, all error pulses 0, `busy`=0.
  - A partial frame in progress is abandoned.

## Timing
- Let t0 = first cycle with `rxd_s`=0. `rxd_s` lags `rxd` by 2 cycles.
- Start-bit sample at t0+`CLKS_PER_BIT/2`. Data bit k (0..7) sampled at t0+`CLKS_PER_BIT/2`+(k+1)·`CLKS_PER_BIT`.
- Stop-bit sample at t0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`, or +10· in the parity build.
- Push occurs at the stop-sample edge. `rx_valid` rises on the following cycle, 2062 cycles after t0 at defaults without parity.
- Error pulses are asserted for exactly the cycle after the stop sample.
- Pop: `rx_valid`/`rx_data` update the cycle after the handshake.
- `busy` is high from the cycle after the falling edge until the cycle after the stop sample.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state compiled in; frame is 8E1; `parity_err` is driven.
- Not defined: frame is 8N1; DATA goes directly to STOP; `parity_err` is constant 0.
- Port list is identical in both builds.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef (IDLE/START/DATA/PARITY/STOP).
  - `UART_CLKS_PER_BIT_DEFAULT`=217.
  - Frame length constants.
- Sub-module `uart_rx_sync_fifo`: parameterised FWFT FIFO (push/pop/full/empty, head output).
- The top holds the synchronizer, bit-timing counter, and FSM.

## Test plan
- Send 0x34 at `CLKS_PER_BIT`=217, `rx_ready`=0 -> `rx_data`=0x34, `rx_valid` rises 2062 cycles after `rxd_s` falls; no error pulses.
- Back-to-back 0x34, 0x35, 0x2A, 0x34, 0x32 with `rx_ready`=0, depth 4:
  - First four bytes held in order.
  - Fifth byte gives `overrun` pulse; FIFO still has 0x34, 0x35, 0x2A, 0x34.
- Same byte stream with `rx_ready`=1 during the fifth stop sample while full -> no overrun; FIFO ends with 0x35, 0x2A, 0x34, 0x32.
- 50-cycle low glitch on `rxd` -> START sample high, back to IDLE; `busy` pulse only; no byte, no flags.
- Frame 0x39 with stop bit forced low -> `frame_err` pulse; FIFO unchanged; next 0x2F after line returns high is received correctly.
- Assert `resetn`=0 mid-DATA of 0x33, release, then send 0x30 -> no partial byte, outputs 0 during reset, 0x30 received. In the `UART_RX_PARITY_EN` build, 0x30 with odd parity bit -> `parity_err` pulse, no push.
